// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding and sizing helpers for wait_state_memory
package mem_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3} state_t;
  localparam int WAIT_W = 4;
  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage with byte-enabled write and registered read
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic                      we,
  input  logic [lanes(DATA_W)-1:0]  be,
  input  logic [AW-1:0]             addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < lanes(DATA_W); i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      if (!we) rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/wait_state_memory.sv
// wait_state_memory: valid/ready data memory with programmable wait states and a one-cycle response
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [lanes(DATA_W)-1:0]  req_be,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [WAIT_W-1:0] CNT_INIT = WAIT_W'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  state_t state, nxt;
  logic [WAIT_W-1:0] cnt, nxt_cnt;
  logic h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata, arr_rdata;
  logic [lanes(DATA_W)-1:0] h_be;
  logic in_range, rd_ok, err_q;
  assign in_range = {1'b0, h_addr} < DEPTH_L;
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign rsp_err = rsp_valid & err_q;
  // the array's read register holds across writes; rd_ok masks it after reset or an out-of-range read
  assign rsp_rdata = rd_ok ? arr_rdata : '0;
  always_comb begin
    nxt = state;
    nxt_cnt = cnt;
    if (state == S_IDLE && req_valid) begin
      nxt = WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
      nxt_cnt = CNT_INIT;
    end else if (state == S_WAIT) begin
      nxt = cnt == '0 ? S_ACCESS : S_WAIT;
      nxt_cnt = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (state == S_ACCESS) begin
      nxt = S_RESP;
    end else if (state == S_RESP) begin
      nxt = S_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      if (state == S_ACCESS) begin
        err_q <= !in_range;
        if (!h_we) rd_ok <= in_range;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (req_ready && req_valid) begin
      h_we <= req_we;
      h_addr <= req_addr;
      h_wdata <= req_wdata;
      h_be <= req_be;
    end
  end
  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (state == S_ACCESS && in_range),
    .we    (h_we),
    .be    (h_be),
    .addr  (h_addr[AW-1:0]),
    .wdata (h_wdata),
    .rdata (arr_rdata)
  );
endmodule
